// File: rtl/multicycle_control_fsm.sv
// Control sequencer for a multicycle CPU datapath: walks each instruction through
// fetch/decode/execute/writeback states and counts retired instructions.
module multicycle_control_fsm #(
  parameter logic [2:0] LW_OP   = 3'b001,
  parameter logic [2:0] SW_OP   = 3'b010,
  parameter logic [2:0] J_OP    = 3'b011,
  parameter logic [2:0] ADD_OP  = 3'b100,
  parameter logic [2:0] ADDI_OP = 3'b101,
  parameter logic [2:0] SUB_OP  = 3'b110,
  parameter int         CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_retired
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    WB_MEM   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    WB_R     = 4'd7,
    EXEC_I   = 4'd8,
    WB_I     = 4'd9,
    JUMP     = 4'd10
  } state_t;

  state_t           state_q;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             op_legal;

  assign state         = state_q;
  assign instr_retired = cnt_q;

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      LW_OP, SW_OP, J_OP, ADD_OP, ADDI_OP, SUB_OP: op_legal = 1'b1;
      default:                                     op_legal = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        FETCH:    if (mem_ready) state_q <= DECODE;
        DECODE: begin
          op_q <= opcode;
          case (opcode)
            LW_OP, SW_OP:    state_q <= MEM_ADDR;
            ADD_OP, SUB_OP:  state_q <= EXEC_R;
            ADDI_OP:         state_q <= EXEC_I;
            J_OP:            state_q <= JUMP;
            default:         state_q <= FETCH;
          endcase
        end
        // Uses the opcode captured in DECODE; the IR may already be changing.
        MEM_ADDR: state_q <= (op_q == LW_OP) ? MEM_RD : MEM_WR;
        MEM_RD:   if (mem_ready) state_q <= WB_MEM;
        MEM_WR: begin
          if (mem_ready) begin
            state_q <= FETCH;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        EXEC_R:   state_q <= WB_R;
        EXEC_I:   state_q <= WB_I;
        WB_MEM, WB_R, WB_I, JUMP: begin
          state_q <= FETCH;
          cnt_q   <= cnt_q + CNT_W'(1);
        end
        default:  state_q <= FETCH;
      endcase
    end
  end

  // Outputs decode the current state; reset gates them off so no strobe leaks
  // out while the sequencer is held.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    illegal_op = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE:   illegal_op = !op_legal;
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b11;
        end
        WB_I:     reg_write = 1'b1;
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
          alu_op    = 2'b01;
        end
        default: ;
      endcase
    end
  end

endmodule
